// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types, port identifiers and byte-enable helper for the
//               two-requester memory arbiter and its lane-alignment logic.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Outstanding-read tracking for the single RAM port
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_I = 2'd1,
        RD_D = 2'd2
    } arb_state_t;

    // Access size encoding as presented on d_size (3 is illegal)
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_t;

    // Requester identifiers used for round-robin history
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    // Byte enables for an access of the given size starting at a lane offset
    function automatic logic [3:0] be_from_size(input logic [1:0] size,
                                                input logic [1:0] offset);
        logic [3:0] base;
        case (size)
            SZ_B:    base = 4'b0001;
            SZ_H:    base = 4'b0011;
            SZ_W:    base = 4'b1111;
            default: base = 4'b0000;
        endcase
        return base << offset;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_align
// Description : Purely combinational lane handling for data accesses: store
//               data replication and byte enables, misalignment detection,
//               and load byte/half extraction with sign or zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misaligned,
    input  logic [1:0]  i_ld_off,
    input  logic [1:0]  i_ld_size,
    input  logic        i_ld_unsigned,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_shifted;

    // Bring the addressed lane down to bit 0; halves sit at offset 0 or 2 so
    // a byte-granular shift covers both sizes.
    assign w_shifted = i_rdata >> {i_ld_off, 3'b000};

    assign o_be = be_from_size(i_size, i_addr_lo);

    // Misalignment: halves on odd bytes, words off a word boundary, size 3
    always_comb begin
        o_misaligned = 1'b0;
        case (i_size)
            SZ_B:    o_misaligned = 1'b0;
            SZ_H:    o_misaligned = i_addr_lo[0];
            SZ_W:    o_misaligned = |i_addr_lo;
            default: o_misaligned = 1'b1;
        endcase
    end

    // Replicate right-justified store data across every lane it could occupy
    always_comb begin
        o_wdata = i_wdata;
        case (i_size)
            SZ_B:    o_wdata = {4{i_wdata[7:0]}};
            SZ_H:    o_wdata = {2{i_wdata[15:0]}};
            default: o_wdata = i_wdata;
        endcase
    end

    // Extract the loaded byte/half and extend it to a full word
    always_comb begin
        o_ld_data = i_rdata;
        case (i_ld_size)
            SZ_B:    o_ld_data = {{24{~i_ld_unsigned & w_shifted[7]}}, w_shifted[7:0]};
            SZ_H:    o_ld_data = {{16{~i_ld_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            default: o_ld_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter placing an instruction-fetch port and an
//               RV32I load/store port onto a single byte-lane RAM port. Grants
//               and RAM strobes are combinational; read responses return one
//               cycle after acceptance. Misaligned data accesses are answered
//               with an error response and never reach the RAM.
//               Define MEM_ARB_STATS_EN to add saturating grant/conflict
//               counters (stat_if_grants, stat_d_grants, stat_conflicts).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 31,
    parameter int DATA_WIDTH = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH:0]   if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH:0]   if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [1:0]            d_size,
    input  logic                  d_unsigned,
    input  logic [ADDR_WIDTH:0]   d_addr,
    input  logic [DATA_WIDTH:0]   d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH:0]   d_rdata,
    output logic                  d_err,
    output logic                  ram_read_req,
    output logic [ADDR_WIDTH:0]   ram_read_addr,
    input  logic [DATA_WIDTH:0]   ram_read_data,
    output logic                  ram_write_enable,
    output logic [3:0]            ram_byte_enable,
    output logic [ADDR_WIDTH:0]   ram_write_addr,
    output logic [DATA_WIDTH:0]   ram_write_data
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]           stat_if_grants,
    output logic [31:0]           stat_d_grants,
    output logic [31:0]           stat_conflicts
`endif
);

    arb_state_t  state_q, state_d;
    logic        rr_last_q, rr_last_d;
    logic        err_pend_q, err_pend_d;
    logic [1:0]  ld_off_q, ld_off_d;
    logic [1:0]  ld_size_q, ld_size_d;
    logic        ld_uns_q, ld_uns_d;

    logic                w_active;
    logic                w_if_win;
    logic                w_d_win;
    logic [ADDR_WIDTH:0] w_if_word;
    logic [ADDR_WIDTH:0] w_d_word;
    logic [3:0]          w_be;
    logic [31:0]         w_st_data;
    logic                w_misaligned;
    logic [31:0]         w_ld_data;

    // Reset is folded in so nothing is granted while the block is held in reset
    assign w_active  = clk_en & rst;
    assign w_if_word = if_addr >> 2;
    assign w_d_word  = d_addr >> 2;

    // A lone requester wins; on a conflict the port that did not win last wins
    assign w_if_win = w_active & if_req & (~d_req  | (rr_last_q == PORT_D));
    assign w_d_win  = w_active & d_req  & (~if_req | (rr_last_q == PORT_IF));

    lsu_lane_align u_lane_align (
        .i_addr_lo     (d_addr[1:0]),
        .i_size        (d_size),
        .i_wdata       (d_wdata),
        .o_be          (w_be),
        .o_wdata       (w_st_data),
        .o_misaligned  (w_misaligned),
        .i_ld_off      (ld_off_q),
        .i_ld_size     (ld_size_q),
        .i_ld_unsigned (ld_uns_q),
        .i_rdata       (ram_read_data),
        .o_ld_data     (w_ld_data)
    );

    // Accept logic: grants, RAM strobes and the next outstanding-read state
    always_comb begin
        state_d          = state_q;
        rr_last_d        = rr_last_q;
        err_pend_d       = err_pend_q;
        ld_off_d         = ld_off_q;
        ld_size_d        = ld_size_q;
        ld_uns_d         = ld_uns_q;
        if_gnt           = 1'b0;
        d_gnt            = 1'b0;
        ram_read_req     = 1'b0;
        ram_read_addr    = '0;
        ram_write_enable = 1'b0;
        ram_byte_enable  = 4'b0000;
        ram_write_addr   = '0;
        ram_write_data   = '0;
        if (w_active) begin
            // Any outstanding response is delivered this cycle
            state_d    = IDLE;
            err_pend_d = 1'b0;
            if (w_if_win) begin
                if_gnt        = 1'b1;
                rr_last_d     = PORT_IF;
                ram_read_req  = 1'b1;
                ram_read_addr = w_if_word;
                state_d       = RD_I;
            end else if (w_d_win) begin
                d_gnt     = 1'b1;
                rr_last_d = PORT_D;
                if (w_misaligned) begin
                    err_pend_d = 1'b1;
                end else if (d_we) begin
                    ram_write_enable = 1'b1;
                    ram_byte_enable  = w_be;
                    ram_write_addr   = w_d_word;
                    ram_write_data   = w_st_data;
                end else begin
                    ram_read_req  = 1'b1;
                    ram_read_addr = w_d_word;
                    state_d       = RD_D;
                    ld_off_d      = d_addr[1:0];
                    ld_size_d     = d_size;
                    ld_uns_d      = d_unsigned;
                end
            end
        end
    end

    // Arbiter state registers; a reset drops any read still in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rr_last_q  <= PORT_IF;
            err_pend_q <= 1'b0;
            ld_off_q   <= 2'b00;
            ld_size_q  <= 2'b00;
            ld_uns_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            err_pend_q <= err_pend_d;
            ld_off_q   <= ld_off_d;
            ld_size_q  <= ld_size_d;
            ld_uns_q   <= ld_uns_d;
        end
    end

    assign if_rvalid = (state_q == RD_I);
    assign if_rdata  = if_rvalid ? ram_read_data : '0;
    assign d_rvalid  = (state_q == RD_D) | err_pend_q;
    assign d_err     = err_pend_q;
    assign d_rdata   = (state_q == RD_D) ? w_ld_data : '0;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_if_q, stat_if_d;
    logic [31:0] stat_d_q, stat_d_d;
    logic [31:0] stat_cf_q, stat_cf_d;

    // Saturating event counters, frozen while clk_en is low
    always_comb begin
        stat_if_d = stat_if_q;
        stat_d_d  = stat_d_q;
        stat_cf_d = stat_cf_q;
        if (if_gnt && !(&stat_if_q)) begin
            stat_if_d = stat_if_q + 32'd1;
        end
        if (d_gnt && !(&stat_d_q)) begin
            stat_d_d = stat_d_q + 32'd1;
        end
        if (w_active && if_req && d_req && !(&stat_cf_q)) begin
            stat_cf_d = stat_cf_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_if_q <= '0;
            stat_d_q  <= '0;
            stat_cf_q <= '0;
        end else begin
            stat_if_q <= stat_if_d;
            stat_d_q  <= stat_d_d;
            stat_cf_q <= stat_cf_d;
        end
    end

    assign stat_if_grants = stat_if_q;
    assign stat_d_grants  = stat_d_q;
    assign stat_conflicts = stat_cf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: directed vector table,
//               hand-written arbitration / reset / stall sequences, and a
//               randomized phase checked against a byte-addressed model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_en = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [1:0]  d_size = 2'd0;
    logic        d_unsigned = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        ram_read_req, ram_write_enable;
    logic [31:0] ram_read_addr, ram_write_addr, ram_write_data;
    logic [31:0] ram_read_data = '0;
    logic [3:0]  ram_byte_enable;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_if_grants, stat_d_grants, stat_conflicts;
`endif

    int checks = 0;
    int failures = 0;

    mem_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .clk_en           (clk_en),
        .if_req           (if_req),
        .if_addr          (if_addr),
        .if_gnt           (if_gnt),
        .if_rvalid        (if_rvalid),
        .if_rdata         (if_rdata),
        .d_req            (d_req),
        .d_we             (d_we),
        .d_size           (d_size),
        .d_unsigned       (d_unsigned),
        .d_addr           (d_addr),
        .d_wdata          (d_wdata),
        .d_gnt            (d_gnt),
        .d_rvalid         (d_rvalid),
        .d_rdata          (d_rdata),
        .d_err            (d_err),
        .ram_read_req     (ram_read_req),
        .ram_read_addr    (ram_read_addr),
        .ram_read_data    (ram_read_data),
        .ram_write_enable (ram_write_enable),
        .ram_byte_enable  (ram_byte_enable),
        .ram_write_addr   (ram_write_addr),
        .ram_write_data   (ram_write_data)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_if_grants   (stat_if_grants),
        .stat_d_grants    (stat_d_grants),
        .stat_conflicts   (stat_conflicts)
`endif
    );

    always #5 clk = ~clk;

    // RAM: registered read data on a read strobe, byte-lane write commit
    logic [31:0] ram [0:63];
    always @(posedge clk) begin
        if (ram_read_req) ram_read_data <= ram[ram_read_addr[5:0]];
        if (ram_write_enable) begin
            for (int b = 0; b < 4; b++)
                if (ram_byte_enable[b]) ram[ram_write_addr[5:0]][8*b +: 8] <= ram_write_data[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        if_req = 1'b0; d_req = 1'b0; clk_en = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); @(negedge clk); rst = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          port_d;
        bit          we;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_ram_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [18];

    task automatic apply_vec(input int idx, input vec_t v);
        @(negedge clk);
        if (v.port_d) begin
            d_req = 1'b1; d_we = v.we; d_size = v.size; d_unsigned = v.uns;
            d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        #1;
        chk($sformatf("v%0d_if_gnt", idx), if_gnt, !v.port_d);
        chk($sformatf("v%0d_d_gnt", idx), d_gnt, v.port_d);
        if (v.exp_err) begin
            chk($sformatf("v%0d_no_rreq", idx), ram_read_req, 1'b0);
            chk($sformatf("v%0d_no_we", idx), ram_write_enable, 1'b0);
        end else if (v.we) begin
            chk($sformatf("v%0d_we", idx), ram_write_enable, 1'b1);
            chk($sformatf("v%0d_be", idx), ram_byte_enable, v.exp_be);
            chk($sformatf("v%0d_waddr", idx), ram_write_addr, v.exp_ram_addr);
            chk($sformatf("v%0d_wdata", idx), ram_write_data, v.exp_wdata);
            chk($sformatf("v%0d_no_rreq", idx), ram_read_req, 1'b0);
        end else begin
            chk($sformatf("v%0d_rreq", idx), ram_read_req, 1'b1);
            chk($sformatf("v%0d_raddr", idx), ram_read_addr, v.exp_ram_addr);
            chk($sformatf("v%0d_no_we", idx), ram_write_enable, 1'b0);
        end
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0;
        #1;
        if (!v.port_d) begin
            chk($sformatf("v%0d_if_rvalid", idx), if_rvalid, 1'b1);
            chk($sformatf("v%0d_if_rdata", idx), if_rdata, v.exp_rdata);
        end else if (v.exp_err) begin
            chk($sformatf("v%0d_err_rvalid", idx), d_rvalid, 1'b1);
            chk($sformatf("v%0d_err", idx), d_err, 1'b1);
            chk($sformatf("v%0d_err_rdata", idx), d_rdata, 32'h0);
        end else if (v.we) begin
            chk($sformatf("v%0d_st_no_rvalid", idx), d_rvalid, 1'b0);
        end else begin
            chk($sformatf("v%0d_d_rvalid", idx), d_rvalid, 1'b1);
            chk($sformatf("v%0d_d_err", idx), d_err, 1'b0);
            chk($sformatf("v%0d_d_rdata", idx), d_rdata, v.exp_rdata);
        end
    endtask

    // ---------------- reference model for random phase ----------------
    logic [7:0] ref_mem [0:255];

    function automatic logic [31:0] ref_load(input int addr, input logic [1:0] size, input bit uns);
        int n = 1 << size;
        longint v = 0;
        for (int k = 0; k < n; k++) v += longint'(ref_mem[addr + k]) << (8 * k);
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    // Watchdog: the bench must never hang
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit        m_last_d, p_if, p_d, p_err, g_if, g_d;
        logic [31:0] p_if_val, p_d_val;
        bit        e_rreq, e_we;
        logic [31:0] e_raddr, e_waddr, e_wdata;
        logic [3:0]  e_be;
        int        a, n;
`ifdef MEM_ARB_STATS_EN
        int        m_cnt_if, m_cnt_d, m_cnt_cf;
`endif

        vecs[0]  = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 4'hF, 32'h4, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        1'b0, 4'h0, 32'h4, 32'h0,        32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h23, 32'hA5,       1'b0, 4'h8, 32'h8, 32'hA5A5A5A5, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h23, 32'h0,        1'b0, 4'h0, 32'h8, 32'h0,        32'h000000A5};
        vecs[4]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h23, 32'h0,        1'b0, 4'h0, 32'h8, 32'h0,        32'hFFFFFFA5};
        vecs[5]  = '{1'b1, 1'b1, 2'd1, 1'b0, 32'h22, 32'h8001,     1'b0, 4'hC, 32'h8, 32'h80018001, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0,        1'b0, 4'h0, 32'h8, 32'h0,        32'hFFFF8001};
        vecs[7]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h22, 32'h0,        1'b0, 4'h0, 32'h8, 32'h0,        32'h00008001};
        vecs[8]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h05, 32'h0,        1'b1, 4'h0, 32'h0, 32'h0,        32'h0};
        vecs[9]  = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h30, 32'h12345678, 1'b0, 4'hF, 32'hC, 32'h12345678, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0,        1'b0, 4'h0, 32'hC, 32'h0,        32'h12345678};
        vecs[11] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h31, 32'h0,        1'b0, 4'h0, 32'hC, 32'h0,        32'h00000056};
        vecs[12] = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h30, 32'h0,        1'b1, 4'h0, 32'h0, 32'h0,        32'h0};
        vecs[13] = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h23, 32'h0,        1'b1, 4'h0, 32'h0, 32'h0,        32'h0};
        vecs[14] = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h20, 32'h1234567F, 1'b0, 4'h1, 32'h8, 32'h7F7F7F7F, 32'h0};
        vecs[15] = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h20, 32'h0,        1'b0, 4'h0, 32'h8, 32'h0,        32'h0000007F};
        vecs[16] = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h32, 32'hCAFEF00D, 1'b1, 4'h0, 32'h0, 32'h0,        32'h0};
        vecs[17] = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0,        1'b0, 4'h0, 32'h8, 32'h0,        32'hFFFF8001};

        // Reset state
        @(negedge clk); @(negedge clk); #1;
        chk("rst_if_gnt", if_gnt, 1'b0);
        chk("rst_d_gnt", d_gnt, 1'b0);
        chk("rst_if_rvalid", if_rvalid, 1'b0);
        chk("rst_d_rvalid", d_rvalid, 1'b0);
        chk("rst_rreq", ram_read_req, 1'b0);
        chk("rst_we", ram_write_enable, 1'b0);
        chk("rst_be", ram_byte_enable, 4'b0000);
        rst = 1'b1;

        for (int i = 0; i < 18; i++) apply_vec(i, vecs[i]);

        // Both requesting continuously: D wins first, then strict alternation
        do_reset();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_unsigned = 1'b0; d_addr = 32'h30;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("rr%0d_d_gnt", k), d_gnt, (k % 2) == 0);
            chk($sformatf("rr%0d_if_gnt", k), if_gnt, (k % 2) == 1);
            @(negedge clk);
        end
        if_req = 1'b0; d_req = 1'b0;
        #1;
`ifdef MEM_ARB_STATS_EN
        chk("rr_stat_conflicts", stat_conflicts, 32'd6);
        chk("rr_stat_if", stat_if_grants, 32'd3);
        chk("rr_stat_d", stat_d_grants, 32'd3);
`endif

        // Reset while a load is outstanding drops the response
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h30;
        #1 chk("mr_gnt", d_gnt, 1'b1);
        @(negedge clk);
        d_req = 1'b0;
        #1 chk("mr_rvalid_before", d_rvalid, 1'b1);
        rst = 1'b0;
        #1 chk("mr_rvalid_in_rst", d_rvalid, 1'b0);
        @(negedge clk); rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("mr%0d_no_d_rvalid", k), d_rvalid, 1'b0);
            chk($sformatf("mr%0d_no_if_rvalid", k), if_rvalid, 1'b0);
            @(negedge clk);
        end

        // Stall with a fetch response outstanding and a load waiting
        if_req = 1'b1; if_addr = 32'h10;
        #1 chk("st_if_gnt", if_gnt, 1'b1);
        chk("st_raddr", ram_read_addr, 32'h4);
        @(negedge clk);
        if_req = 1'b0; clk_en = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_unsigned = 1'b0; d_addr = 32'h30;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("st%0d_if_rvalid", k), if_rvalid, 1'b1);
            chk($sformatf("st%0d_if_rdata", k), if_rdata, 32'hDEADBEEF);
            chk($sformatf("st%0d_d_gnt", k), d_gnt, 1'b0);
            chk($sformatf("st%0d_rreq", k), ram_read_req, 1'b0);
            chk($sformatf("st%0d_we", k), ram_write_enable, 1'b0);
            @(negedge clk);
        end
        clk_en = 1'b1;
        #1;
        chk("st_resume_if_rvalid", if_rvalid, 1'b1);
        chk("st_resume_if_rdata", if_rdata, 32'hDEADBEEF);
        chk("st_resume_d_gnt", d_gnt, 1'b1);
        chk("st_resume_raddr", ram_read_addr, 32'hC);
        @(negedge clk);
        d_req = 1'b0;
        #1;
        chk("st_resume_d_rvalid", d_rvalid, 1'b1);
        chk("st_resume_d_rdata", d_rdata, 32'h12345678);
        chk("st_resume_if_done", if_rvalid, 1'b0);

        // Randomized traffic against the byte-addressed model
        do_reset();
        for (int w = 0; w < 64; w++)
            for (int b = 0; b < 4; b++) ref_mem[4*w + b] = ram[w][8*b +: 8];
        m_last_d = 1'b0; p_if = 1'b0; p_d = 1'b0; p_err = 1'b0; g_if = 1'b0; g_d = 1'b0;
        p_if_val = '0; p_d_val = '0;
`ifdef MEM_ARB_STATS_EN
        m_cnt_if = 0; m_cnt_d = 0; m_cnt_cf = 0;
`endif
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (g_if) if_req = 1'b0;
            if (g_d) d_req = 1'b0;
            if (!if_req && ($urandom % 2 == 1)) begin
                if_req = 1'b1; if_addr = $urandom % 256;
            end
            if (!d_req && ($urandom % 2 == 1)) begin
                d_req = 1'b1;
                d_we = 1'($urandom % 2);
                d_size = ($urandom % 16 == 0) ? 2'd3 : 2'($urandom % 3);
                d_unsigned = 1'($urandom % 2);
                a = $urandom % 256;
                if ($urandom % 4 != 0) begin
                    if (d_size == 2'd1) a = a & ~1;
                    if (d_size == 2'd2) a = a & ~3;
                end
                d_addr = a;
                d_wdata = $urandom;
            end
            clk_en = ($urandom % 8) != 0;
            #1;
            chk("r_if_rvalid", if_rvalid, p_if);
            if (p_if) chk("r_if_rdata", if_rdata, p_if_val);
            chk("r_d_rvalid", d_rvalid, p_d | p_err);
            if (p_d || p_err) begin
                chk("r_d_err", d_err, p_err);
                chk("r_d_rdata", d_rdata, p_err ? 32'h0 : p_d_val);
            end
            g_if = 1'b0; g_d = 1'b0;
            e_rreq = 1'b0; e_we = 1'b0; e_raddr = '0; e_waddr = '0; e_wdata = '0; e_be = '0;
            if (clk_en) begin
                p_if = 1'b0; p_d = 1'b0; p_err = 1'b0;
                if (if_req && d_req) begin
                    if (m_last_d) g_if = 1'b1; else g_d = 1'b1;
                end else begin
                    g_if = if_req; g_d = d_req;
                end
`ifdef MEM_ARB_STATS_EN
                if (if_req && d_req) m_cnt_cf++;
                if (g_if) m_cnt_if++;
                if (g_d) m_cnt_d++;
`endif
            end
            chk("r_if_gnt", if_gnt, g_if);
            chk("r_d_gnt", d_gnt, g_d);
            if (g_if) begin
                m_last_d = 1'b0;
                e_rreq = 1'b1; e_raddr = if_addr / 4;
                p_if = 1'b1; p_if_val = ref_load(int'(if_addr / 4) * 4, 2'd2, 1'b1);
            end else if (g_d) begin
                m_last_d = 1'b1;
                a = int'(d_addr);
                n = 1 << d_size;
                if (d_size == 2'd3 || (a % n) != 0) begin
                    p_err = 1'b1;
                end else if (d_we) begin
                    e_we = 1'b1; e_waddr = a / 4;
                    e_be = 4'(((1 << n) - 1) << (a % 4));
                    e_wdata = (n == 1) ? d_wdata[7:0] * 32'h01010101 :
                              (n == 2) ? d_wdata[15:0] * 32'h00010001 : d_wdata;
                    for (int k = 0; k < n; k++) ref_mem[a + k] = d_wdata[8*k +: 8];
                end else begin
                    e_rreq = 1'b1; e_raddr = a / 4;
                    p_d = 1'b1; p_d_val = ref_load(a, d_size, d_unsigned);
                end
            end
            chk("r_rreq", ram_read_req, e_rreq);
            if (e_rreq) chk("r_raddr", ram_read_addr, e_raddr);
            chk("r_we", ram_write_enable, e_we);
            if (e_we) begin
                chk("r_be", ram_byte_enable, e_be);
                chk("r_waddr", ram_write_addr, e_waddr);
                chk("r_wdata", ram_write_data, e_wdata);
            end
        end
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0;
`ifdef MEM_ARB_STATS_EN
        #1;
        chk("r_stat_if", stat_if_grants, m_cnt_if);
        chk("r_stat_d", stat_d_grants, m_cnt_d);
        chk("r_stat_cf", stat_conflicts, m_cnt_cf);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
